// File: rtl/ram_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter_pkg                                                       |
// | Shared owner encoding and defaults for the data RAM port arbiter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  // Width of a counter that must reach limit-1.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter_if                                                        |
// | Requester and RAM-side signals of the arbiter; slave = arbiter side.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_flush_i;
  logic              inst_gnt_o;
  logic              inst_rvalid_o;
  logic [DATA_W-1:0] inst_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_wstrb_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;

  logic              ram_write_enable_o;
  logic [3:0]        ram_write_select_o;
  logic [ADDR_W-1:0] ram_write_addr_o;
  logic [DATA_W-1:0] ram_write_data_o;
  logic [ADDR_W-1:0] ram_read_addr_o;
  logic [DATA_W-1:0] ram_read_data_i;

  modport slave (
    input  inst_req_i, inst_addr_i, inst_flush_i,
    output inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    input  data_req_i, data_we_i, data_wstrb_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output ram_write_enable_o, ram_write_select_o, ram_write_addr_o,
    output ram_write_data_o, ram_read_addr_o,
    input  ram_read_data_i
  );

  modport master (
    output inst_req_i, inst_addr_i, inst_flush_i,
    input  inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    output data_req_i, data_we_i, data_wstrb_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  ram_write_enable_o, ram_write_select_o, ram_write_addr_o,
    input  ram_write_data_o, ram_read_addr_o,
    output ram_read_data_i
  );

endinterface

`default_nettype wire

// File: rtl/ram_arb_resp_reg.sv
// +----------------------------------------------------------------------------+
// | ram_arb_resp_reg                                                           |
// | One-cycle registered response stage with fetch flush qualification.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_arb_resp_reg
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire owner_e            owner,
  input  wire logic              is_store,
  input  wire logic              flush,
  input  wire logic [DATA_W-1:0] rdata_in,
  output logic                   inst_rvalid,
  output logic [DATA_W-1:0]      inst_rdata,
  output logic                   data_rvalid,
  output logic [DATA_W-1:0]      data_rdata
);

  owner_e            r_owner;
  logic              r_is_store;
  logic              r_valid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_NONE;
      r_is_store <= 1'b0;
      r_valid    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_owner    <= owner;
      r_is_store <= is_store;
      // A fetch flushed in its own grant cycle never produces a response.
      r_valid    <= (owner == OWNER_DATA) || ((owner == OWNER_INST) && !flush);
      if (owner != OWNER_NONE) begin
        r_rdata <= rdata_in;
      end
    end
  end

  // A flush or reset in the response cycle itself also drops the response.
  assign inst_rvalid = r_valid && (r_owner == OWNER_INST) && !flush && !rst;
  assign data_rvalid = r_valid && (r_owner == OWNER_DATA) && !rst;
  assign inst_rdata  = (r_owner == OWNER_INST) ? r_rdata : '0;
  assign data_rdata  = ((r_owner == OWNER_DATA) && !r_is_store) ? r_rdata : '0;

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter                                                           |
// | Shares the data RAM port between fetch and load/store requesters.         |
// | Option: RAM_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input wire logic          clk,
  input wire logic          rst,
  ram_port_arbiter_if.slave bus
);

  logic              w_inst_prio;
  logic              w_inst_gnt;
  logic              w_data_gnt;
  logic              w_store;
  logic [ADDR_W-1:0] w_read_addr;
  owner_e            w_owner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic w_conflict;
  logic r_rr_last_data;  // 1 when data won the most recent conflict

  assign w_conflict  = bus.inst_req_i && bus.data_req_i;
  assign w_inst_prio = r_rr_last_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last_data <= 1'b0;
    end else if (w_conflict) begin
      r_rr_last_data <= w_data_gnt;
    end
  end
`else
  localparam int              CNT_W        = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_inst_prio = (r_starve_cnt == c_starve_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (bus.inst_req_i && !w_inst_gnt) begin
      if (r_starve_cnt != c_starve_max) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`endif

  assign w_inst_gnt = !rst && bus.inst_req_i && (!bus.data_req_i || w_inst_prio);
  assign w_data_gnt = !rst && bus.data_req_i && !w_inst_gnt;
  assign w_store    = w_data_gnt && bus.data_we_i;

  always_comb begin
    w_owner = OWNER_NONE;
    if (w_inst_gnt) begin
      w_owner = OWNER_INST;
    end else if (w_data_gnt) begin
      w_owner = OWNER_DATA;
    end
  end

  assign bus.inst_gnt_o = w_inst_gnt;
  assign bus.data_gnt_o = w_data_gnt;

  // Write address/data follow the data port unconditionally; enable gates them.
  assign w_read_addr            = w_inst_gnt ? bus.inst_addr_i : bus.data_addr_i;
  assign bus.ram_read_addr_o    = w_read_addr;
  assign bus.ram_write_enable_o = w_store;
  assign bus.ram_write_select_o = w_store ? bus.data_wstrb_i : 4'b0000;
  assign bus.ram_write_addr_o   = bus.data_addr_i;
  assign bus.ram_write_data_o   = bus.data_wdata_i;

  ram_arb_resp_reg #(
    .DATA_W (DATA_W)
  ) u_resp (
    .clk         (clk),
    .rst         (rst),
    .owner       (w_owner),
    .is_store    (w_store),
    .flush       (bus.inst_flush_i),
    .rdata_in    (bus.ram_read_data_i),
    .inst_rvalid (bus.inst_rvalid_o),
    .inst_rdata  (bus.inst_rdata_o),
    .data_rvalid (bus.data_rvalid_o),
    .data_rdata  (bus.data_rdata_o)
  );

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 4KB data RAM (one write port, one read address, combinational read data) between the instruction-fetch requester and the load/store (MEM) requester.
- Grants at most one request per cycle and drives the RAM port combinationally from the winning request.
- Returns read data or a write ack one cycle later through a registered response stage.
- Sits between the IF/MEM stages and the ram module inside myCPU.

Parameters:
- ADDR_W, 32, width of requester and RAM address buses (matches RAM_ADDR_BUS)
- DATA_W, 32, data width (matches GPR_BUS)
- STARVE_LIMIT, 4, consecutive denied cycles after which the instruction requester is forced to win

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inst_req_i  in  1  fetch request valid
- inst_addr_i  in  ADDR_W  fetch byte address
- inst_flush_i  in  1  discard any fetch response due next cycle (branch redirect)
- inst_gnt_o  out  1  fetch request accepted this cycle
- inst_rvalid_o  out  1  fetch response valid
- inst_rdata_o  out  DATA_W  fetch data
- data_req_i  in  1  load/store request valid
- data_we_i  in  1  1 = store, 0 = load
- data_wstrb_i  in  4  store byte lanes
- data_addr_i  in  ADDR_W  load/store byte address
- data_wdata_i  in  DATA_W  store data
- data_gnt_o  out  1  load/store request accepted this cycle
- data_rvalid_o  out  1  load data valid, or store ack
- data_rdata_o  out  DATA_W  load data (0 for store ack)
- ram_write_enable_o  out  1  to RAM write enable
- ram_write_select_o  out  4  to RAM byte select
- ram_write_addr_o  out  ADDR_W  to RAM write address
- ram_write_data_o  out  DATA_W  to RAM write data
- ram_read_addr_o  out  ADDR_W  to RAM read address
- ram_read_data_i  in  DATA_W  from RAM combinational read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Accept:
  - A request is accepted when req and gnt are both high in the same cycle.
  - gnt is combinational from the req inputs and the arbiter state.
  - A requester holds addr, we, wstrb and wdata stable until accepted.
- Arbitration (default, fixed priority):
  - Only one requester asserts req: it is granted.
  - Both assert req: data wins, unless starve_cnt == STARVE_LIMIT-1, in which case inst wins.
- starve_cnt:
  - Increments each cycle inst_req_i=1 and inst is denied.
  - Clears on an inst grant or when inst_req_i=0.
  - Saturates at STARVE_LIMIT-1.
- RAM drive in the grant cycle:
  - ram_read_addr_o = addr of the winner.
  - Data store: ram_write_enable_o=1, ram_write_select_o=data_wstrb_i, ram_write_addr_o=data_addr_i, ram_write_data_o=data_wdata_i.
  - In all other cases write enable and select are 0.
  - Address and data outputs are don't-care when there is no grant; drive them from data_* to avoid muxing.
- A store with wstrb=0 is accepted and acked and writes nothing.
- Response stage (registered):
  - On the clock edge after an accept, the winner's rvalid goes to 1 for exactly one cycle.
  - rdata = ram_read_data_i sampled in the grant cycle; 0 for a store.
  - Response latency is fixed at 1. Back-to-back accepts produce back-to-back responses, one per cycle, throughput 1/cycle.
- Store then load to the same address in consecutive cycles: the load returns the new data, because the RAM write has completed before the load's read cycle.
- inst_flush_i:
  - If high in the grant cycle of a fetch, or in the cycle its response is registered, the response is suppressed: inst_rvalid_o stays 0.
  - A flushed grant is still counted as a grant for starve_cnt.
- No requests: gnt=0, write enable 0, rvalid 0 next cycle.
- Reset values: inst_rvalid_o=0, data_rvalid_o=0, inst_rdata_o=0, data_rdata_o=0, starve_cnt=0, rr_last=INST. A reset mid-operation drops any pending response.
- While rst=1:
  - Both gnt outputs are 0.
  - ram_write_enable_o=0 combinationally, so a reset cycle never writes the RAM.

Optional Feature:
- Macro RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On conflict, grant goes to the requester not granted on the last conflict.
  - rr_last is a 1-bit register updated only on conflict cycles.
  - starve_cnt logic is removed.
- Undefined: fixed data priority with the starvation counter, as above.

Decomposition:
- Shared package/defines (defines.vh): arbiter owner encoding OWNER_NONE=2'd0, OWNER_INST=2'd1, OWNER_DATA=2'd2, and STARVE_LIMIT default.
- Natural sub-module: ram_arb_resp_reg. It holds the response register (owner, is_store, rdata, valid) and applies the flush qualification.
- Grant logic stays in the top module.

Test Plan:
- Inst-only: fetch addr 0x0000_0010 with RAM word 0xDEADBEEF -> inst_gnt_o=1 same cycle; inst_rvalid_o=1 next cycle with 0xDEADBEEF; data_rvalid_o stays 0.
- Store then load: store 0x1122_3344, wstrb=4'b0011, to 0x20 over old 0xAABBCCDD; load 0x20 next cycle -> store ack rdata=0; load returns 0xAABB3344.
- Contention: both requests held for 6 cycles, STARVE_LIMIT=4, macro undefined -> data granted cycles 0-2, inst granted cycle 3, data cycle 4, inst cycle 5 is denied (counter restarted).
- Round robin: same stimulus with RAM_ARB_ROUND_ROBIN_EN -> grants alternate data, inst, data, inst...
- Flush: fetch granted at cycle N, inst_flush_i=1 at N+1 -> inst_rvalid_o=0 at N+1; the next unflushed fetch responds normally.
- Reset mid-op: store granted at N, rst=1 at N+1 -> data_rvalid_o=0 at N+1; no RAM write during the rst cycles; both gnt outputs 0 while rst=1.
